// File: rtl/ccd_pkg.sv
// Shared types and defaults for the CCD correlated-double-sampling block.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package ccd_pkg;

  localparam int ADC_W_DEF  = 12;
  localparam int PIX_W_DEF  = 10;
  localparam int LINE_W_DEF = 10;
  localparam int FIFO_DEPTH = 4;
  // Settle counter width; it covers SETTLE_CYCLES values up to 255.
  localparam int SETTLE_W   = 8;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE_REF,
    WAIT_SIG,
    SETTLE_SIG,
    PUSH
  } cds_state_t;

endpackage

// File: rtl/cds_fifo.sv
// Four-entry first-word-fall-through result FIFO for the CDS sampler.
// Latency: a write is visible on rd_data/!empty the cycle after it is accepted.
// Backpressure: writes are refused when full, unless a read happens in the same cycle.
module cds_fifo
  import ccd_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [W-1:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_wr;
  logic          do_rd;

  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_rd   = rd_en && !empty;
  // A read in the same cycle frees a slot, so a write into a full FIFO still lands.
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr];

  // Storage, pointers and occupancy; storage is cleared so outputs read zero after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ccd_cds_sampler.sv
// CCD correlated-double-sampler: strobes reset/signal levels off phase edges, queues ref-sig per pixel.
// Latency: SETTLE_CYCLES after each detected phase edge to its strobe; result valid 1 cycle after PUSH.
// Backpressure: 4-entry FIFO with valid/ready; a PUSH into a full FIFO drops and sets sticky overflow.
// Optional build macro CDS_TEST_PATTERN_EN adds test_mode (result = pixel XOR line).
module ccd_cds_sampler
  import ccd_pkg::*;
#(
  parameter int ADC_W         = ADC_W_DEF,
  parameter int PIX_W         = PIX_W_DEF,
  parameter int LINE_W        = LINE_W_DEF,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              phi_p,
  input  logic              phi_r,
  input  logic              phi_l1,
  input  logic              phi_l2,
  input  logic [ADC_W-1:0]  adc_data,
  output logic              smp_ref,
  output logic              smp_sig,
  output logic [ADC_W-1:0]  out_data,
  output logic [PIX_W-1:0]  out_pix,
  output logic [LINE_W-1:0] out_line,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overflow
`ifdef CDS_TEST_PATTERN_EN
  ,
  input  logic              test_mode
`endif
);

  localparam int ENTRY_W = ADC_W + PIX_W + LINE_W;
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

  logic                phi_p_q, phi_r_q, phi_l1_q, phi_l2_q;
  logic                p_rise, r_fall, l2_fall;
  cds_state_t          state, state_nxt;
  logic [SETTLE_W-1:0] cnt;
  logic                settle_done;
  logic                push;
  logic [ADC_W-1:0]    ref_lvl, sig_lvl, result;
  logic [PIX_W-1:0]    pix_cnt;
  logic [LINE_W-1:0]   line_cnt;
  logic                fifo_full, fifo_empty, pop;
  logic [ENTRY_W-1:0]  rd_entry;
  logic                unused_phi_l1;

  // One register stage on every phase; edges are the current input against that copy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phi_p_q  <= 1'b0;
      phi_r_q  <= 1'b0;
      phi_l1_q <= 1'b0;
      phi_l2_q <= 1'b0;
    end else begin
      phi_p_q  <= phi_p;
      phi_r_q  <= phi_r;
      phi_l1_q <= phi_l1;
      phi_l2_q <= phi_l2;
    end
  end

  assign p_rise  = phi_p & ~phi_p_q;
  assign r_fall  = ~phi_r & phi_r_q;
  assign l2_fall = ~phi_l2 & phi_l2_q;
  // phi_l1 carries no sampling event of its own.
  assign unused_phi_l1 = phi_l1_q;

  assign settle_done = (cnt == SETTLE_LAST);

  // State register and settle counter; the counter restarts on every state change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt == state && (state == SETTLE_REF || state == SETTLE_SIG))
        cnt <= cnt + SETTLE_W'(1);
      else
        cnt <= '0;
    end
  end

  // Next state and strobes; the strobe fires in the last settle cycle, and enable=0 kills everything.
  always_comb begin
    state_nxt = state;
    smp_ref   = 1'b0;
    smp_sig   = 1'b0;
    push      = 1'b0;
    case (state)
      IDLE:       if (r_fall) state_nxt = SETTLE_REF;
      SETTLE_REF: if (settle_done) begin
                    smp_ref   = 1'b1;
                    state_nxt = WAIT_SIG;
                  end
      WAIT_SIG:   if (l2_fall) state_nxt = SETTLE_SIG;
      SETTLE_SIG: if (settle_done) begin
                    smp_sig   = 1'b1;
                    state_nxt = PUSH;
                  end
      PUSH:       begin
                    push      = 1'b1;
                    state_nxt = IDLE;
                  end
      default:    state_nxt = IDLE;
    endcase
    if (!enable) begin
      state_nxt = IDLE;
      smp_ref   = 1'b0;
      smp_sig   = 1'b0;
      push      = 1'b0;
    end
  end

  // Capture the ADC word on each strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_lvl <= '0;
      sig_lvl <= '0;
    end else begin
      if (smp_ref) ref_lvl <= adc_data;
      if (smp_sig) sig_lvl <= adc_data;
    end
  end

  // CDS difference, clamped at zero when the signal level exceeds the reset level.
  always_comb begin
    result = (ref_lvl >= sig_lvl) ? (ref_lvl - sig_lvl) : '0;
`ifdef CDS_TEST_PATTERN_EN
    if (test_mode) result = ADC_W'(pix_cnt) ^ ADC_W'(line_cnt);
`endif
  end

  // Pixel/line position; a line start takes priority over the PUSH pixel increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_cnt  <= '0;
      line_cnt <= '0;
    end else if (!enable) begin
      pix_cnt  <= '0;
      line_cnt <= '0;
    end else if (p_rise) begin
      pix_cnt  <= '0;
      line_cnt <= line_cnt + LINE_W'(1);
    end else if (push) begin
      pix_cnt  <= pix_cnt + PIX_W'(1);
    end
  end

  assign pop = out_valid & out_ready;

  // Sticky drop flag, cleared only by reset or disabling readout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      overflow <= 1'b0;
    else if (!enable)
      overflow <= 1'b0;
    else if (push && fifo_full && !pop)
      overflow <= 1'b1;
  end

  cds_fifo #(
    .W (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data ({result, pix_cnt, line_cnt}),
    .rd_en   (pop),
    .rd_data (rd_entry),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign out_valid = ~fifo_empty;
  assign out_data  = rd_entry[ENTRY_W-1 -: ADC_W];
  assign out_pix   = rd_entry[LINE_W +: PIX_W];
  assign out_line  = rd_entry[LINE_W-1:0];

endmodule

// File: tb/tb_ccd_cds_sampler.sv
// Scoreboard bench for ccd_cds_sampler: directed CDS scenarios plus randomized pixels.
// Latency: expects strobes SETTLE cycles after each phase edge, results 1 cycle after PUSH.
// Backpressure: models the 4-deep FIFO as a queue; drops predicted when the queue is full.
module tb_ccd_cds_sampler;

  localparam int AW  = 12;
  localparam int PW  = 10;
  localparam int LW  = 10;
  localparam int S   = 2;
  localparam int ENT = AW + PW + LW;

  logic          clk = 1'b0;
  logic          rst, enable, phi_p, phi_r, phi_l1, phi_l2, out_ready;
  logic [AW-1:0] adc_data, out_data;
  logic [PW-1:0] out_pix;
  logic [LW-1:0] out_line;
  logic          smp_ref, smp_sig, out_valid, overflow;
`ifdef CDS_TEST_PATTERN_EN
  logic          test_mode = 1'b0;
`endif

  int vectors = 0;
  int errors  = 0;
  int n_ref = 0, n_sig = 0, exp_nref = 0, exp_nsig = 0;

  logic [ENT-1:0] exp_q[$];
  logic [ENT-1:0] mon_e;
  logic [PW-1:0]  m_pix;
  logic [LW-1:0]  m_line;
  logic           m_ovf;
  logic [AW-1:0]  cur_ref;
  logic           rnd_ready = 1'b0;

  ccd_cds_sampler #(
    .ADC_W(AW), .PIX_W(PW), .LINE_W(LW), .SETTLE_CYCLES(S)
  ) dut (
`ifdef CDS_TEST_PATTERN_EN
    .test_mode (test_mode),
`endif
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .phi_p     (phi_p),
    .phi_r     (phi_r),
    .phi_l1    (phi_l1),
    .phi_l2    (phi_l2),
    .adc_data  (adc_data),
    .smp_ref   (smp_ref),
    .smp_sig   (smp_sig),
    .out_data  (out_data),
    .out_pix   (out_pix),
    .out_line  (out_line),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [AW-1:0] cds(input logic [AW-1:0] r, input logic [AW-1:0] s);
    return (r >= s) ? r - s : '0;
  endfunction

  // Monitor: counts strobe cycles and checks every handshaken result against the queue.
  always @(negedge clk) begin
    if (smp_ref) n_ref++;
    if (smp_sig) n_sig++;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL unexpected_output: got data 0x%0h pix %0d line %0d with nothing expected",
                 out_data, out_pix, out_line);
      end else begin
        mon_e = exp_q.pop_front();
        check("out_data", out_data, mon_e[ENT-1 -: AW]);
        check("out_pix",  out_pix,  mon_e[LW +: PW]);
        check("out_line", out_line, mon_e[LW-1:0]);
      end
    end
  end

  // Random backpressure during the randomized phase.
  always @(posedge clk) begin
    if (rnd_ready) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    phi_l1 = ~phi_l1;
  endtask

  // phi_r falling edge, settle, reset-level strobe; optional stray phi_l2 edge while settling.
  task automatic ref_phase(input logic [AW-1:0] rv, input bit spur);
    tick(); phi_r = 1'b0; adc_data = AW'($urandom);
    for (int i = 1; i < S; i++) begin
      tick(); adc_data = AW'($urandom);
      if (i == 1) begin phi_r = 1'b1; if (spur) phi_l2 = 1'b0; end
    end
    tick(); phi_r = 1'b1; phi_l2 = 1'b1; adc_data = rv; cur_ref = rv;
    @(negedge clk);
    check("smp_ref_timing", smp_ref, 1'b1);
    exp_nref++;
  endtask

  // Wait in WAIT_SIG, optionally with a stray phi_r edge, then drop phi_l2.
  task automatic sig_edge(input int ws, input bit spur);
    for (int i = 0; i < ws; i++) begin
      tick(); adc_data = AW'($urandom);
      phi_r = (spur && i == 0) ? 1'b0 : 1'b1;
    end
    tick(); adc_data = AW'($urandom); phi_r = 1'b1; phi_l2 = 1'b0;
  endtask

  // Signal-level settle and strobe, then predict the PUSH outcome from the model queue.
  task automatic sig_push(input logic [AW-1:0] sv, input bit chk_lat);
    for (int i = 1; i < S; i++) begin
      tick(); adc_data = AW'($urandom);
      if (i == 1) phi_l2 = 1'b1;
    end
    tick(); phi_l2 = 1'b1; adc_data = sv;
    @(negedge clk);
    check("smp_sig_timing", smp_sig, 1'b1);
    exp_nsig++;
    tick(); adc_data = AW'($urandom);
    @(negedge clk);
    if (chk_lat) check("valid_in_push_cycle", out_valid, 1'b0);
    #1;
    if (exp_q.size() < 4) exp_q.push_back({cds(cur_ref, sv), m_pix, m_line});
    else m_ovf = 1'b1;
    m_pix = m_pix + PW'(1);
    tick(); adc_data = AW'($urandom);
    @(negedge clk);
    if (chk_lat) check("valid_after_push", out_valid, 1'b1);
    check("overflow", overflow, m_ovf);
  endtask

  task automatic do_pixel(input logic [AW-1:0] rv, input logic [AW-1:0] sv, input int ws,
                          input bit spur, input bit chk_lat);
    ref_phase(rv, spur);
    sig_edge(ws, spur);
    sig_push(sv, chk_lat);
  endtask

  task automatic line_edge();
    tick(); phi_p = 1'b1;
    m_pix = '0; m_line = m_line + LW'(1);
    tick(); phi_p = 1'b0;
  endtask

  task automatic enable_pulse();
    tick(); enable = 1'b0;
    m_pix = '0; m_line = '0; m_ovf = 1'b0;
    tick(); tick(); enable = 1'b1;
  endtask

  task automatic drain();
    rnd_ready = 1'b0;
    tick(); out_ready = 1'b1;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
    check("drain_complete", exp_q.size() == 0, 1'b1);
    @(negedge clk);
    check("empty_after_drain", out_valid, 1'b0);
  endtask

  initial begin
    int nsig0;
    rst = 1'b1; enable = 1'b1; phi_p = 1'b0; phi_r = 1'b1; phi_l1 = 1'b0; phi_l2 = 1'b1;
    out_ready = 1'b0; adc_data = '0; m_pix = '0; m_line = '0; m_ovf = 1'b0; cur_ref = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {smp_ref, smp_sig, out_valid, out_data, out_pix, out_line, overflow}, '0);
    @(posedge clk); #1; rst = 1'b0;
    tick(); tick();

    // Basic difference and clamp-at-zero, with output latency.
    out_ready = 1'b1;
    do_pixel(12'h800, 12'h300, 1, 1'b0, 1'b1);
    do_pixel(12'h100, 12'h400, 2, 1'b0, 1'b1);

    // Line start between pixels.
    for (int k = 0; k < 3; k++) do_pixel(AW'($urandom), AW'($urandom), 1, 1'b1, 1'b0);
    line_edge();
    do_pixel(12'h555, 12'h055, 1, 1'b0, 1'b0);
    drain();

    // Fill the FIFO with no consumer: four held, fifth dropped.
    enable_pulse();
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) do_pixel(AW'($urandom), AW'($urandom), 1, 1'b0, 1'b0);
    @(negedge clk);
    check("overflow_after_fill", overflow, 1'b1);
    check("valid_while_full", out_valid, 1'b1);

    // Disable in WAIT_SIG: no signal strobe, overflow cleared, held entries still drain.
    ref_phase(AW'($urandom), 1'b0);
    tick(); enable = 1'b0;
    m_pix = '0; m_line = '0; m_ovf = 1'b0;
    nsig0 = n_sig;
    tick(); phi_l2 = 1'b0;
    tick(); phi_l2 = 1'b1;
    repeat (S + 3) tick();
    @(negedge clk);
    check("no_smp_sig_disabled", n_sig, nsig0);
    check("overflow_cleared", overflow, 1'b0);
    drain();
    tick(); enable = 1'b1;

    // Reset during SETTLE_SIG with one entry held: everything flushed, no result.
    out_ready = 1'b0;
    do_pixel(12'h0F0, 12'h010, 1, 1'b0, 1'b0);
    ref_phase(12'h700, 1'b0);
    sig_edge(1, 1'b0);
    tick(); phi_l2 = 1'b1;
    rst = 1'b1;
    exp_q.delete(); m_pix = '0; m_line = '0; m_ovf = 1'b0;
    @(negedge clk);
    check("outputs_in_reset", {smp_ref, smp_sig, out_valid, out_data, out_pix, out_line, overflow}, '0);
    tick(); tick(); rst = 1'b0;
    repeat (6) tick();
    @(negedge clk);
    check("no_output_after_reset", out_valid, 1'b0);
    out_ready = 1'b1;
    do_pixel(12'h345, 12'h045, 1, 1'b0, 1'b1);

    // Randomized pixels, gaps, stray edges, line starts and backpressure.
    rnd_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 7) == 0) line_edge();
      do_pixel(AW'($urandom), AW'($urandom), int'($urandom_range(1, 4)),
               bit'($urandom_range(0, 1)), 1'b0);
    end
    drain();

    check("smp_ref_count", n_ref, exp_nref);
    check("smp_sig_count", n_sig, exp_nsig);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/ccd_cds_sampler.md
CCD_CDS_SAMPLER -- requirements
Module: ccd_cds_sampler

Interface
REQ-001 SHALL have parameter ADC_W, 12, ADC sample width in bits.
REQ-002 SHALL have parameter PIX_W, 10, pixel index width in bits.
REQ-003 SHALL have parameter LINE_W, 10, line index width in bits.
REQ-004 SHALL have parameter SETTLE_CYCLES, 4, wait in clk cycles from a phase edge to its sample strobe; legal range 1..255.
REQ-005 SHALL have one clock and one reset: reset is asynchronous and active-high.
REQ-006 SHALL have port clk  input  1  system clock, shared with the CCD phase generator.
REQ-007 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-008 SHALL have port enable  input  1  readout enable.
REQ-009 SHALL have ports phi_p, phi_r, phi_l1, phi_l2  input  1 each  CCD clock phases, already synchronous to clk.
REQ-010 SHALL have port adc_data  input  ADC_W  external ADC sample.
REQ-011 SHALL have ports smp_ref and smp_sig  output  1 each  sample strobes for the reset level and the signal level.
REQ-012 SHALL have port out_data  output  ADC_W  CDS result.
REQ-013 SHALL have ports out_pix  output  PIX_W  and  out_line  output  LINE_W  giving the pixel and line of the result.
REQ-014 SHALL have port out_valid  output  1, and port out_ready  input  1, forming a valid/ready handshake.
REQ-015 SHALL have port overflow  output  1  sticky flag, set when a result is dropped.

Function
REQ-016 SHALL register every phi_* input once; an edge SHALL be detected by comparing the current input with its registered copy.
REQ-017 SHALL implement the FSM IDLE, SETTLE_REF, WAIT_SIG, SETTLE_SIG, PUSH.
- IDLE -> SETTLE_REF on a phi_r falling edge while enable=1.
- SETTLE_REF -> WAIT_SIG after SETTLE_CYCLES.
- WAIT_SIG -> SETTLE_SIG on a phi_l2 falling edge.
- SETTLE_SIG -> PUSH after SETTLE_CYCLES.
- PUSH -> IDLE after 1 cycle.
REQ-018 SHALL pulse smp_ref for 1 cycle exactly SETTLE_CYCLES cycles after the edge-detect cycle, and SHALL capture adc_data as ref in that same cycle; smp_sig/sig SHALL follow the same rule.
REQ-019 SHALL compute the result as ref-sig when ref>=sig, else 0 (unsigned saturation, ADC_W bits).
REQ-020 In PUSH, SHALL write {result, pixel, line} to the FIFO, then increment the pixel counter.
REQ-021 The pixel counter SHALL wrap at its all-ones value to 0.
REQ-022 SHALL respond to a phi_p rising edge by clearing the pixel counter and incrementing the line counter (wrapping); the line counter SHALL win if this coincides with a PUSH increment.
REQ-023 SHALL provide a 4-entry FIFO; out_valid SHALL be asserted when non-empty, and the head entry SHALL pop on out_valid&out_ready.
REQ-024 A result SHALL appear on the output 1 cycle after PUSH when the FIFO was empty.
REQ-025 On PUSH with the FIFO full and no pop in the same cycle: the result SHALL be dropped and overflow set to 1; a simultaneous pop SHALL make the push succeed.
REQ-026 When enable=0: FSM SHALL go to IDLE next cycle, counters SHALL clear, overflow SHALL clear, strobes SHALL be suppressed, and FIFO contents SHALL remain drainable.
REQ-027 SHALL ignore phi_r edges outside IDLE and phi_l2 edges outside WAIT_SIG.

Reset
REQ-028 On rst=1 (asynchronous): FSM=IDLE, FIFO empty, counters 0, ref/sig 0.
REQ-029 Under reset, all outputs SHALL be 0: smp_ref, smp_sig, out_valid, out_data, out_pix, out_line, overflow.
REQ-030 Reset mid-sequence SHALL discard the partial pixel; no result is emitted.

Configuration
REQ-031 With CDS_TEST_PATTERN_EN defined: SHALL add port test_mode (input, 1); when test_mode=1, the result SHALL be pixel index XOR line index, truncated or zero-extended to ADC_W, in place of ref-sig.
REQ-032 Without CDS_TEST_PATTERN_EN: the test_mode port and its logic SHALL be absent.

Structure
REQ-033 Package ccd_pkg SHALL hold the FSM state enum, the FIFO depth constant (4), and the default widths.
REQ-034 The FIFO SHALL be the sub-module cds_fifo (parameterised width, depth 4, with full/empty outputs).

Verification
REQ-035 SETTLE_CYCLES=2, adc_data=0x800 at smp_ref, 0x300 at smp_sig -> out_data=0x500, out_pix=0, out_line=0, out_valid 1 cycle after PUSH.
REQ-036 ref=0x100, sig=0x400 -> out_data=0x000.
REQ-037 out_ready=0, 5 pixels -> 4 entries held, overflow=1; then out_ready=1 -> out_pix sequence 0,1,2,3.
REQ-038 3 pixels, phi_p rising edge, 1 pixel -> last result out_pix=0, out_line=1.
REQ-039 rst pulse during SETTLE_SIG -> no output, all outputs 0; next full sequence -> out_pix=0.
REQ-040 enable=0 during WAIT_SIG -> no smp_sig; FIFO entries already held still drain; overflow=0.
